mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port op  in  6  opcode field of the current instruction register.
REQ-004 SHALL have port funct  in  6  function field of the current instruction register.
REQ-005 SHALL have port zero  in  1  ALU equal/zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access completes this cycle; used only with CTRL_MEMWAIT_EN.
REQ-007 SHALL have outputs PCWr, IRWr, RFWr, DMWr  out  1 each  write enables.
REQ-008 SHALL have outputs EXTOp  out  2  immediate-extender mode: 00 zero, 01 sign, 10 load-upper.
REQ-009 SHALL have outputs NPCOp  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register.
REQ-010 SHALL have outputs ALUOp  out  3, ALUSrc  out  1, RegDst  out  2, WDSel  out  2  datapath selects.
REQ-011 SHALL have outputs state  out  3  current state; illegal  out  1  one-cycle unknown-opcode pulse; instr_cnt  out  32  retired-instruction count.

Function
REQ-012 SHALL support addu, subu, jr (op 000000), ori, lw, sw, beq, lui, j, jal; anything else is illegal.
REQ-013 SHALL implement states FETCH, DECODE, EXE, MEM, WB; outputs decode from state plus op/funct.
REQ-014 FETCH: IRWr=1, PCWr=1, NPCOp=00; next state DECODE.
REQ-015 DECODE: j -> PCWr=1, NPCOp=10, next FETCH; jal -> same plus RFWr=1, RegDst=10 ($31), WDSel=10 (PC+4); jr -> PCWr=1, NPCOp=11, next FETCH; illegal -> illegal=1, no write enables, next FETCH; others -> EXE.
REQ-016 EXE: beq -> PCWr=zero, NPCOp=01, EXTOp=01, next FETCH; lw/sw -> ALUSrc=1, EXTOp=01, ALUOp=add, next MEM; addu/subu/ori/lui -> next WB.
REQ-017 EXTOp SHALL be 00 for ori, 10 for lui, 01 for lw/sw/beq, 00 otherwise.
REQ-018 MEM: sw -> DMWr=1, next FETCH; lw -> next WB.
REQ-019 WB: RFWr=1; RegDst=01 (rd) for R-type else 00 (rt); WDSel=01 for lw else 00; next FETCH.
REQ-020 All write enables SHALL be 0 in any state/opcode combination not listed above.
REQ-021 instr_cnt SHALL increment by 1 on every transition into FETCH from a non-FETCH state, including illegal and not-taken beq; wraps from FFFFFFFF to 0.
REQ-022 Latency: j/jal/jr 2 cycles, beq 3, R-type/ori/lui/sw 4, lw 5 (without wait states).

Reset
REQ-023 reset low SHALL asynchronously force state=FETCH, instr_cnt=0, illegal=0.
REQ-024 While reset is low all write enables SHALL be 0 regardless of state; reset mid-instruction aborts it without any write.
REQ-025 First FETCH after reset deassertion SHALL occur on the first rising clk edge with reset high.

Configuration
REQ-026 Macro CTRL_MEMWAIT_EN: when defined, FETCH and MEM SHALL hold state while mem_ready=0, with IRWr/PCWr (FETCH) and DMWr (MEM) asserted only in the cycle mem_ready=1.
REQ-027 Without CTRL_MEMWAIT_EN, mem_ready SHALL be ignored and FETCH/MEM last exactly one cycle.

Structure
REQ-028 Opcode/funct constants, state encodings, EXTOp/NPCOp/ALUOp/WDSel codes SHALL live in shared package ctrl_pkg.
REQ-029 Combinational instruction classification SHALL be sub-module ctrl_decode (op, funct -> one-hot class + illegal).

Verification
REQ-030 ori (op 001101) from reset: states FETCH,DECODE,EXE,WB then FETCH; EXTOp=00 in EXE/WB; RFWr=1 only in WB; instr_cnt 0->1.
REQ-031 lw (op 100011): 5 cycles; EXTOp=01, ALUSrc=1 in EXE; WDSel=01, RFWr=1 in WB; DMWr never 1.
REQ-032 beq with zero=0 then zero=1: PCWr=0 then PCWr=1 with NPCOp=01 in EXE; both return to FETCH; instr_cnt +2.
REQ-033 op 111111: illegal=1 for one cycle in DECODE, no write enable asserted, next FETCH, instr_cnt +1.
REQ-034 CTRL_MEMWAIT_EN, sw with mem_ready=0 for 3 cycles in MEM: state holds MEM, DMWr=0 for 3 cycles, DMWr=1 on cycle 4, then FETCH.
REQ-035 reset pulled low during MEM of sw: state=FETCH immediately, DMWr=0, instr_cnt=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, state encoding,
// datapath select codes and instruction-class indices.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtLui  = 2'b10;

  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcReg    = 2'b11;

  localparam logic [2:0] AluNop = 3'd0;
  localparam logic [2:0] AluAdd = 3'd1;
  localparam logic [2:0] AluSub = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluLui = 3'd4;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc4 = 2'b10;

  // Bit positions in the one-hot instruction-class vector.
  localparam int unsigned ClsAddu = 0;
  localparam int unsigned ClsSubu = 1;
  localparam int unsigned ClsJr   = 2;
  localparam int unsigned ClsOri  = 3;
  localparam int unsigned ClsLw   = 4;
  localparam int unsigned ClsSw   = 5;
  localparam int unsigned ClsBeq  = 6;
  localparam int unsigned ClsLui  = 7;
  localparam int unsigned ClsJ    = 8;
  localparam int unsigned ClsJal  = 9;
  localparam int unsigned NumCls  = 10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: op/funct to a one-hot class vector,
// with illegal raised when no class matches.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [NumCls-1:0] cls,
  output logic              illegal
);

  always_comb begin
    cls = '0;
    unique case (op)
      OpRtype: begin
        unique case (funct)
          FnAddu:  cls[ClsAddu] = 1'b1;
          FnSubu:  cls[ClsSubu] = 1'b1;
          FnJr:    cls[ClsJr]   = 1'b1;
          default: cls          = '0;
        endcase
      end
      OpOri:   cls[ClsOri] = 1'b1;
      OpLw:    cls[ClsLw]  = 1'b1;
      OpSw:    cls[ClsSw]  = 1'b1;
      OpBeq:   cls[ClsBeq] = 1'b1;
      OpLui:   cls[ClsLui] = 1'b1;
      OpJ:     cls[ClsJ]   = 1'b1;
      OpJal:   cls[ClsJal] = 1'b1;
      default: cls         = '0;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller (FETCH/DECODE/EXE/MEM/WB) with a retired
// instruction counter. Define CTRL_MEMWAIT_EN to stall FETCH/MEM on mem_ready.
module mc_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic [1:0]  EXTOp,
  output logic [1:0]  NPCOp,
  output logic [2:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  state_e            state_q, state_d;
  logic [31:0]       cnt_q;
  logic [NumCls-1:0] cls;
  logic              dec_illegal;
  logic              mem_go;
  logic              pc_wr, ir_wr, rf_wr, dm_wr;

  ctrl_decode u_decode (
    .op      (op),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

`ifdef CTRL_MEMWAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    NPCOp   = NpcPc4;
    ALUOp   = AluNop;
    ALUSrc  = 1'b0;
    RegDst  = RegDstRt;
    WDSel   = WdAlu;
    illegal = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_wr = mem_go;
        pc_wr = mem_go;
        if (mem_go) state_d = StDecode;
      end
      StDecode: begin
        state_d = StExe;
        if (cls[ClsJ] || cls[ClsJal]) begin
          pc_wr   = 1'b1;
          NPCOp   = NpcJump;
          state_d = StFetch;
        end
        if (cls[ClsJal]) begin
          rf_wr  = 1'b1;
          RegDst = RegDstRa;
          WDSel  = WdPc4;
        end
        if (cls[ClsJr]) begin
          pc_wr   = 1'b1;
          NPCOp   = NpcReg;
          state_d = StFetch;
        end
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = StFetch;
        end
      end
      StExe: begin
        state_d = StWb;
        if (cls[ClsBeq]) begin
          pc_wr   = zero;
          NPCOp   = NpcBranch;
          ALUOp   = AluSub;
          state_d = StFetch;
        end
        if (cls[ClsLw] || cls[ClsSw]) begin
          ALUSrc  = 1'b1;
          ALUOp   = AluAdd;
          state_d = StMem;
        end
        if (cls[ClsAddu]) ALUOp = AluAdd;
        if (cls[ClsSubu]) ALUOp = AluSub;
        if (cls[ClsOri]) begin
          ALUOp  = AluOr;
          ALUSrc = 1'b1;
        end
        if (cls[ClsLui]) begin
          ALUOp  = AluLui;
          ALUSrc = 1'b1;
        end
      end
      StMem: begin
        dm_wr = cls[ClsSw] & mem_go;
        if (mem_go) state_d = cls[ClsLw] ? StWb : StFetch;
      end
      StWb: begin
        rf_wr   = 1'b1;
        RegDst  = (cls[ClsAddu] || cls[ClsSubu]) ? RegDstRd : RegDstRt;
        WDSel   = cls[ClsLw] ? WdMem : WdAlu;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    EXTOp = ExtZero;
    if (cls[ClsLui]) EXTOp = ExtLui;
    else if (cls[ClsLw] || cls[ClsSw] || cls[ClsBeq]) EXTOp = ExtSign;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != StFetch && state_d == StFetch) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Write enables are masked while reset is held so an aborted instruction never commits.
  assign PCWr      = pc_wr & reset;
  assign IRWr      = ir_wr & reset;
  assign RFWr      = rf_wr & reset;
  assign DMWr      = dm_wr & reset;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle expected outputs for every
// instruction class, then reset-abort and memory-wait sequences.
module tb_mc_ctrl;

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] LUI = 6'b001111;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] BAD = 6'b111111;
  localparam logic [5:0] ADDU = 6'b100001;
  localparam logic [5:0] SUBU = 6'b100011;
  localparam logic [5:0] JR   = 6'b001000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        PCWr, IRWr, RFWr, DMWr, ALUSrc, illegal;
  logic [1:0]  EXTOp, NPCOp, RegDst, WDSel;
  logic [2:0]  ALUOp, state;
  logic [31:0] instr_cnt;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RFWr      (RFWr),
    .DMWr      (DMWr),
    .EXTOp     (EXTOp),
    .NPCOp     (NPCOp),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .WDSel     (WDSel),
    .state     (state),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op, funct;
    logic        zero;
    logic [2:0]  st;
    logic        pc, ir, rf, dm;
    logic [1:0]  ext, npc;
    logic [2:0]  alu;
    logic        asrc;
    logic [1:0]  rdst, wds;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void v(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input logic [2:0] st, input logic pc, input logic ir,
                            input logic rf, input logic dm, input logic [1:0] ext,
                            input logic [1:0] npc, input logic [2:0] alu, input logic asrc,
                            input logic [1:0] rdst, input logic [1:0] wds, input logic ill,
                            input logic [31:0] cnt);
    vec_t r;
    r.op = o; r.funct = f; r.zero = z; r.st = st; r.pc = pc; r.ir = ir; r.rf = rf;
    r.dm = dm; r.ext = ext; r.npc = npc; r.alu = alu; r.asrc = asrc; r.rdst = rdst;
    r.wds = wds; r.ill = ill; r.cnt = cnt;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {state,PCWr,IRWr,RFWr,DMWr,EXTOp,NPCOp,ALUOp,ALUSrc,RegDst,WDSel,illegal}
  function automatic logic [31:0] outs();
    return {12'd0, state, PCWr, IRWr, RFWr, DMWr, EXTOp, NPCOp, ALUOp, ALUSrc, RegDst, WDSel,
            illegal};
  endfunction

  initial begin
    //     op   funct zero st pc ir rf dm ext npc alu as rd wd il cnt
    v(ORI, 0,    0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(ORI, 0,    0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(ORI, 0,    0,   2, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    v(ORI, 0,    0,   4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(LW,  0,    0,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v(LW,  0,    0,   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v(LW,  0,    0,   2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    v(LW,  0,    0,   3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v(LW,  0,    0,   4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    v(SW,  0,    0,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    v(SW,  0,    0,   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    v(SW,  0,    0,   2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2);
    v(SW,  0,    0,   3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2);
    v(BEQ, 0,    0,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    v(BEQ, 0,    0,   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    v(BEQ, 0,    0,   2, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 3);
    v(BEQ, 0,    1,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4);
    v(BEQ, 0,    1,   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4);
    v(BEQ, 0,    1,   2, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 4);
    v(R,   ADDU, 0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    v(R,   ADDU, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    v(R,   ADDU, 0,   2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5);
    v(R,   ADDU, 0,   4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5);
    v(R,   SUBU, 0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    v(R,   SUBU, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    v(R,   SUBU, 0,   2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 6);
    v(R,   SUBU, 0,   4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6);
    v(LUI, 0,    0,   0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 7);
    v(LUI, 0,    0,   1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 7);
    v(LUI, 0,    0,   2, 0, 0, 0, 0, 2, 0, 4, 1, 0, 0, 0, 7);
    v(LUI, 0,    0,   4, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 7);
    v(J,   0,    0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    v(J,   0,    0,   1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 8);
    v(JAL, 0,    0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    v(JAL, 0,    0,   1, 1, 0, 1, 0, 0, 2, 0, 0, 2, 2, 0, 9);
    v(R,   JR,   0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    v(R,   JR,   0,   1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 10);
    v(BAD, 0,    0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
    v(BAD, 0,    0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11);
    v(R,   0,    0,   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    v(R,   0,    0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    v(SW,  0,    0,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 13);

    // Reset held: FETCH, counter clear, no write enables.
    reset = 1'b0; op = ORI; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);
    check("rst_wen", {28'd0, PCWr, IRWr, RFWr, DMWr}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      vec_t r;
      r = vecs[i];
      op = r.op; funct = r.funct; zero = r.zero;
      #1;
      check($sformatf("row%0d_outs", i), outs(),
            {12'd0, r.st, r.pc, r.ir, r.rf, r.dm, r.ext, r.npc, r.alu, r.asrc, r.rdst, r.wds,
             r.ill});
      check($sformatf("row%0d_cnt", i), instr_cnt, r.cnt);
      @(negedge clk);
    end

    // sw now in DECODE; advance into MEM, then reset asynchronously mid-cycle.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_pre_state", {29'd0, state}, 32'd3);
    check("abort_pre_dmwr", {31'd0, DMWr}, 32'd1);
    check("abort_pre_cnt", instr_cnt, 32'd13);
    #1 reset = 1'b0;
    #1;
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_wen", {28'd0, PCWr, IRWr, RFWr, DMWr}, 32'd0);
    check("abort_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_fetch", {30'd0, IRWr, PCWr}, 32'd3);
    @(negedge clk);
    #1;
    check("release_decode", {29'd0, state}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("sw_done_state", {29'd0, state}, 32'd0);
    check("sw_done_cnt", instr_cnt, 32'd1);

`ifdef CTRL_MEMWAIT_EN
    mem_ready = 1'b0;
    #1;
    check("fwait_wen", {30'd0, IRWr, PCWr}, 32'd0);
    @(negedge clk);
    #1;
    check("fwait_hold", {29'd0, state}, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("fwait_go", {30'd0, IRWr, PCWr}, 32'd3);
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("mwait%0d_state", k), {29'd0, state}, 32'd3);
      check($sformatf("mwait%0d_dmwr", k), {31'd0, DMWr}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("mwait_go_state", {29'd0, state}, 32'd3);
    check("mwait_go_dmwr", {31'd0, DMWr}, 32'd1);
    @(negedge clk);
    #1;
    check("mwait_fetch", {29'd0, state}, 32'd0);
    check("mwait_cnt", instr_cnt, 32'd2);
`else
    mem_ready = 1'b0;
    #1;
    check("nowait_fetch", {30'd0, IRWr, PCWr}, 32'd3);
    repeat (3) @(negedge clk);
    #1;
    check("nowait_mem_state", {29'd0, state}, 32'd3);
    check("nowait_dmwr", {31'd0, DMWr}, 32'd1);
    @(negedge clk);
    #1;
    check("nowait_fetch2", {29'd0, state}, 32'd0);
    check("nowait_cnt", instr_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
